// File: rtl/led_pwm_pkg.sv
// -----------------------------------------------------------------------------
// led_pwm_pkg
//   Shared definitions for the LED PWM fader: PWM resolution, the per-channel
//   level type, default prescale/fade-step values and the saturating step
//   helper used by each channel when fading is built in.
//
//   Contents:
//     PWM_BITS            PWM resolution in bits (8 -> 256 ticks per period)
//     PWM_MAX             largest pwm_cnt / level value (255)
//     level_t             unsigned PWM_BITS-wide brightness level
//     DEFAULT_PRESCALE    default clk cycles per PWM tick
//     DEFAULT_FADE_STEP   default level change per PWM period while fading
//     step_toward()       move a level toward a target by at most one step,
//                         landing exactly on the target (no overshoot, no wrap)
// -----------------------------------------------------------------------------
package led_pwm_pkg;

    localparam int PWM_BITS          = 8;
    localparam int PWM_MAX           = (1 << PWM_BITS) - 1;
    localparam int DEFAULT_PRESCALE  = 64;
    localparam int DEFAULT_FADE_STEP = 4;

    typedef logic [PWM_BITS-1:0] level_t;

    // Returns cur moved toward tgt by step, clamped at tgt. The upward sum is
    // formed one bit wider so a large step near the top cannot wrap past 255;
    // the downward case compares the remaining gap against the step so the
    // subtraction itself can never go below zero.
    function automatic level_t step_toward(input level_t cur,
                                           input level_t tgt,
                                           input level_t step);
        logic [PWM_BITS:0] sum;
        level_t            result;
        sum    = {1'b0, cur} + {1'b0, step};
        result = cur;
        if (cur < tgt) begin
            result = (sum >= {1'b0, tgt}) ? tgt : sum[PWM_BITS-1:0];
        end else if (cur > tgt) begin
            result = ((cur - tgt) <= step) ? tgt : (cur - step);
        end
        return result;
    endfunction

endpackage : led_pwm_pkg

// File: rtl/led_pwm_channel.sv
// -----------------------------------------------------------------------------
// led_pwm_channel
//   One LED channel: holds the current brightness level, moves it toward the
//   channel target once per PWM period, and drives a registered PWM output by
//   comparing the level against the shared PWM counter.
//
//   Build option LED_PWM_FADER_FADE_EN:
//     defined   -> level steps toward target by FADE_STEP per period,
//                  saturating exactly on the target; a target change mid-fade
//                  simply reverses direction from the current level.
//     undefined -> level loads the target directly at period end (the step
//                  lands on a period boundary, so the PWM waveform never
//                  glitches); FADE_STEP is unused.
//
//   Ports:
//     clk         system clock, rising edge
//     reset_n     asynchronous active-low reset
//     period_end  one-cycle strobe at the last tick of each PWM period
//     target      level this channel is heading for
//     pwm_cnt     shared PWM phase counter
//     led_out     registered PWM drive, 1 = lit
//     mismatch    combinational (level != target), OR-ed into busy by the top
// -----------------------------------------------------------------------------
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int FADE_STEP = DEFAULT_FADE_STEP
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   period_end,
    input  level_t target,
    input  level_t pwm_cnt,
    output logic   led_out,
    output logic   mismatch
);

    localparam level_t STEP = level_t'(FADE_STEP);

    level_t level_q, level_d;
    logic   led_q,   led_d;

`ifndef LED_PWM_FADER_FADE_EN
    // Step size has no meaning when levels load directly.
    level_t unused_step;
    assign unused_step = STEP;
`endif

    // NOTE: every always_comb output gets a default assignment first so no
    // path through the block leaves it unassigned, which would infer a latch.
    always_comb begin
        level_d = level_q;
        if (period_end) begin
`ifdef LED_PWM_FADER_FADE_EN
            level_d = step_toward(level_q, target, STEP);
`else
            level_d = target;
`endif
        end
        // Strict compare: level 0 never lights, level 255 lights 255 of 256.
        led_d = (level_q > pwm_cnt);
    end

    assign mismatch = (level_q != target);
    assign led_out  = led_q;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order across blocks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

endmodule : led_pwm_channel

// File: rtl/led_pwm_fader.sv
// -----------------------------------------------------------------------------
// led_pwm_fader
//   Multi-channel LED PWM driver with optional brightness fading. The on/off
//   pattern and shared brightness are registered once; each channel's target
//   is brightness when its pattern bit is set, else 0. A shared prescaler and
//   8-bit PWM counter time all channels; channel levels only change at the end
//   of a full PWM period, so short pattern pulses matter only if they are
//   present at that sampling instant.
//
//   Build option LED_PWM_FADER_FADE_EN: see led_pwm_channel (fade vs. direct
//   load at period end).
//
//   Parameters:
//     N_LEDS      number of LED channels
//     PRESCALE    clk cycles per PWM tick, 1..65535 (1 = tick every cycle)
//     FADE_STEP   level change per PWM period while fading, 1..255
//
//   Ports:
//     clk         system clock, rising edge
//     reset_n     asynchronous active-low reset
//     pattern_in  LED on/off pattern from the LED PIO, same clock domain
//     brightness  on-level shared by all channels
//     led_out     registered PWM drive to the LED pins, 1 = lit
//     busy        registered: high while any channel level differs from target
// -----------------------------------------------------------------------------
module led_pwm_fader
    import led_pwm_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int PRESCALE  = DEFAULT_PRESCALE,
    parameter int FADE_STEP = DEFAULT_FADE_STEP
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] pattern_in,
    input  logic [7:0]        brightness,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy
);

    localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] presc_q,   presc_d;
    level_t             pwm_cnt_q, pwm_cnt_d;
    logic [N_LEDS-1:0]  pattern_q, pattern_d;
    level_t             bright_q,  bright_d;
    logic               busy_q,    busy_d;

    logic               tick;
    logic               period_end;
    logic [N_LEDS-1:0]  mismatch;

    always_comb begin
        // With PRESCALE=1 the counter is stuck at 0 == PRESC_LAST, so tick is
        // asserted every cycle.
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : (presc_q + PRESC_W'(1));
        pwm_cnt_d  = tick ? (pwm_cnt_q + level_t'(1)) : pwm_cnt_q;
        period_end = tick && (pwm_cnt_q == level_t'(PWM_MAX));
        pattern_d  = pattern_in;
        bright_d   = brightness;
        busy_d     = |mismatch;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            pattern_q <= '0;
            bright_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            pattern_q <= pattern_d;
            bright_q  <= bright_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
        level_t target;
        assign target = pattern_q[i] ? bright_q : '0;

        led_pwm_channel #(
            .FADE_STEP (FADE_STEP)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .period_end (period_end),
            .target     (target),
            .pwm_cnt    (pwm_cnt_q),
            .led_out    (led_out[i]),
            .mismatch   (mismatch[i])
        );
    end

    assign busy = busy_q;

endmodule : led_pwm_fader

// File: tb/tb_led_pwm_fader.sv
// -----------------------------------------------------------------------------
// tb_led_pwm_fader
//   Three fader instances with different PRESCALE/FADE_STEP share one
//   stimulus stream. A reference model tracks each channel's level from the
//   cycle count since reset release (PWM phase = (cycles / PRESCALE) mod 256,
//   period end every 256*PRESCALE cycles) and queues the expected led_out/busy
//   for every clock edge; a separate monitor pops and compares on the falling
//   edge. The model follows LED_PWM_FADER_FADE_EN like the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_pwm_fader;

    localparam int N  = 8;
    localparam int NI = 3;

    localparam int P_A = 1, S_A = 4;
    localparam int P_B = 1, S_B = 255;
    localparam int P_C = 2, S_C = 7;

`ifdef LED_PWM_FADER_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    typedef struct packed {
        logic [NI-1:0][N-1:0] led;
        logic [NI-1:0]        busy;
    } exp_t;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] pattern_in;
    logic [7:0]   brightness;
    logic [N-1:0] led_a, led_b, led_c;
    logic         busy_a, busy_b, busy_c;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];

    // reference model state
    int           m_level [NI][N];
    int           m_cycle;
    logic [N-1:0] m_pat;
    int           m_bright;

    led_pwm_fader #(.N_LEDS(N), .PRESCALE(P_A), .FADE_STEP(S_A)) u_a (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in),
        .brightness(brightness), .led_out(led_a), .busy(busy_a));
    led_pwm_fader #(.N_LEDS(N), .PRESCALE(P_B), .FADE_STEP(S_B)) u_b (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in),
        .brightness(brightness), .led_out(led_b), .busy(busy_b));
    led_pwm_fader #(.N_LEDS(N), .PRESCALE(P_C), .FADE_STEP(S_C)) u_c (
        .clk(clk), .reset_n(reset_n), .pattern_in(pattern_in),
        .brightness(brightness), .led_out(led_c), .busy(busy_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cfg_presc(input int k);
        case (k)
            0:       return P_A;
            1:       return P_B;
            default: return P_C;
        endcase
    endfunction

    function automatic int cfg_step(input int k);
        case (k)
            0:       return S_A;
            1:       return S_B;
            default: return S_C;
        endcase
    endfunction

    // One period-end update: fade by at most step and stop on target, or load.
    function automatic int next_level(input int cur, input int tgt, input int step);
        if (!FADE_EN)         return tgt;
        if (cur + step <= tgt) return cur + step;
        if (cur < tgt)         return tgt;
        if (cur - step >= tgt) return cur - step;
        return tgt;
    endfunction

    task automatic model_step();
        exp_t e;
        int   presc, tgt;
        e = '0;
        if (!reset_n) begin
            m_cycle  = 0;
            m_pat    = '0;
            m_bright = 0;
            for (int k = 0; k < NI; k++)
                for (int i = 0; i < N; i++) m_level[k][i] = 0;
        end else begin
            for (int k = 0; k < NI; k++) begin
                presc = cfg_presc(k);
                for (int i = 0; i < N; i++) begin
                    tgt = m_pat[i] ? m_bright : 0;
                    e.led[k][i] = (m_level[k][i] > ((m_cycle / presc) % 256));
                    if (m_level[k][i] != tgt) e.busy[k] = 1'b1;
                    if ((m_cycle % (256 * presc)) == (256 * presc - 1))
                        m_level[k][i] = next_level(m_level[k][i], tgt, cfg_step(k));
                end
            end
            m_pat    = pattern_in;
            m_bright = int'(brightness);
            m_cycle++;
        end
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got busy/led %h required %h", name, cyc, act, req);
        end
    endtask

    // model: one expected entry per rising edge
    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // monitor: compare on the falling edge, away from the active edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (!reset_n) e = '0;
                check("inst_a", {busy_a, led_a}, {e.busy[0], e.led[0]});
                check("inst_b", {busy_b, led_b}, {e.busy[1], e.led[1]});
                check("inst_c", {busy_c, led_c}, {e.busy[2], e.led[2]});
            end
        end
    end

    // Inputs change 2 time units after a rising edge and hold for 'cycles' edges.
    task automatic hold(input logic [N-1:0] pat, input logic [7:0] br, input int cycles);
        pattern_in = pat;
        brightness = br;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    initial begin : stimulus
        reset_n    = 1'b1;
        pattern_in = 8'hFF;
        brightness = 8'hFF;
        #1 reset_n = 1'b0;
        // reset held with everything asking to be lit
        repeat (20) @(posedge clk);
        #2;
        reset_n = 1'b1;
        hold(8'h00, 8'd0, 4);
        // full fade-up to 255 in steps of 4 (64 periods for inst_a)
        hold(8'h01, 8'd255, 66 * 256);
        // reset mid-fade, then restart from level 0
        reset_n = 1'b0;
        hold(8'h01, 8'd100, 5);
        reset_n = 1'b1;
        hold(8'h01, 8'd100, 28 * 256);
        // fade down from 100 to 0 without underflow
        hold(8'h00, 8'd100, 28 * 256);
        // step 7 toward 250 must land exactly on 250
        hold(8'h01, 8'd250, 38 * 512);
        // step 255 reaches 128 in one period: half duty
        hold(8'h01, 8'd128, 3 * 256);
        // channel 7 only, brightness 200
        hold(8'h80, 8'd200, 3 * 256);
        // all channels up, then brightness lowered mid-fade (direction reverses)
        hold(8'hFF, 8'd200, 10 * 256);
        hold(8'hFF, 8'd60, 10 * 256);
        // random patterns, including pulses far shorter than a PWM period
        for (int r = 0; r < 24; r++)
            hold(N'($urandom), 8'($urandom), int'($urandom_range(1, 700)));
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_led_pwm_fader

// File: doc/led_pwm_fader.md
LED_PWM_FADER -- requirements
Module: led_pwm_fader

Interface
REQ-001 SHALL have parameter N_LEDS, default 8, number of LED channels.
REQ-002 SHALL have parameter PRESCALE, default 64, clk cycles per PWM tick (legal range 1..65535).
REQ-003 SHALL have parameter FADE_STEP, default 4, level change per PWM period while fading (legal range 1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port pattern_in  input  N_LEDS  LED on/off pattern, driven by the LED PIO out_port, same clock domain.
REQ-007 SHALL have port brightness  input  8  on-level target shared by all channels.
REQ-008 SHALL have port led_out  output  N_LEDS  registered PWM drive to the physical LED pins, 1 = lit.
REQ-009 SHALL have port busy  output  1  high while any channel level differs from its target.

Function
REQ-010 SHALL register pattern_in and brightness once (pattern_q, bright_q); all targets derive from these, giving 1-cycle input latency.
REQ-011 SHALL compute target[i] = pattern_q[i] ? bright_q : 0.
REQ-012 SHALL run a prescaler 0..PRESCALE-1, asserting tick for one cycle when the count equals PRESCALE-1, then wrapping to 0; PRESCALE=1 gives tick every cycle.
REQ-013 SHALL run an 8-bit pwm_cnt that increments on tick, wrapping 255->0; period_end = tick && pwm_cnt==255.
REQ-014 SHALL update level[i] only on period_end: toward target[i] by FADE_STEP, saturating exactly at target[i] (no overshoot, no 8-bit wrap).
REQ-015 SHALL register led_out[i] = (level[i] > pwm_cnt) every cycle; level 0 -> constantly 0, level 255 -> high 255 of 256 ticks.
REQ-016 SHALL reverse direction from the current level if target[i] changes mid-fade; no restart from 0 or 255.
REQ-017 SHALL treat a brightness change with pattern bit set as a new target and fade to it by REQ-014.
REQ-018 SHALL drive busy as a registered OR over channels of (level[i] != target[i]).
REQ-019 SHALL ignore pattern_in pulses shorter than one PWM period except through their effect at period_end sampling (targets sampled at period_end only).

Reset
REQ-020 SHALL, while reset_n=0, asynchronously clear prescaler, pwm_cnt, all level[i], pattern_q, bright_q, led_out (all 0) and busy (0).
REQ-021 SHALL, on reset deassertion mid-fade, restart from level 0 with prescaler at 0; first tick occurs PRESCALE cycles after release.

Configuration
REQ-022 SHALL use macro LED_PWM_FADER_FADE_EN.
REQ-023 SHALL, with LED_PWM_FADER_FADE_EN defined, behave per REQ-014/016/017.
REQ-024 SHALL, without LED_PWM_FADER_FADE_EN, load level[i] = target[i] directly at period_end (glitch-free step change); FADE_STEP unused; busy high at most until the next period_end.

Structure
REQ-025 SHALL place PWM_BITS (8), level type (8-bit unsigned) and FADE_STEP/PRESCALE defaults in shared package led_pwm_pkg.
REQ-026 SHALL implement one channel (level register, step/saturate, compare, led_out flop) as sub-module led_pwm_channel, instantiated N_LEDS times; prescaler and pwm_cnt shared in top.

Verification
REQ-027 SHALL cover: reset held, pattern_in=8'hFF, brightness=255 -> led_out=0, busy=0 throughout reset.
REQ-028 SHALL cover: PRESCALE=1, FADE_STEP=255, pattern_in=8'h01, brightness=128 -> after first period_end led_out[0] high exactly 128 of every 256 cycles, others 0, busy falls.
REQ-029 SHALL cover: FADE_STEP=4, brightness=255, pattern 0->8'h01 -> level[0] reaches 255 after 64 periods (saturates from 252), busy high for exactly 64 periods.
REQ-030 SHALL cover: fade-up to level 100 then pattern bit cleared -> level decreases 100,96,...,4,0 with no underflow wrap.
REQ-031 SHALL cover: brightness=250, FADE_STEP=7 -> final level 250 exactly (245 then 250, no overshoot).
REQ-032 SHALL cover: build without LED_PWM_FADER_FADE_EN, pattern 0->8'h80, brightness=200 -> level[7]=200 at first period_end, duty 200/256 immediately after.
